adder_bist: RTL and testbench
=============================

ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter SEED, default 32'h0000_0001, LFSR seed; value 0 SHALL be replaced by 1.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  begin run; sampled in IDLE only.
REQ-005 iter  in  16  iteration count, latched on accepted start.
REQ-006 dut_x, dut_y  out  32  operands to Adder32 x/y.
REQ-007 dut_sub  out  1  to Adder32 sub (1 = x-y).
REQ-008 dut_f  in  32  Adder32 result.
REQ-009 dut_cf, dut_of, dut_sf, dut_zf  in  1 each  Adder32 flags.
REQ-010 busy  out  1  run in progress.
REQ-011 done  out  1  one-cycle pulse at run end.
REQ-012 pass  out  1  run finished with zero errors; held until next start.
REQ-013 err_cnt  out  16  mismatching vectors, saturating at 16'hFFFF.
REQ-014 fail_x, fail_y  out  32; fail_sub  out  1  first failing vector of the run.

Function
REQ-015 FSM states IDLE, APPLY, CHECK, DONE; IDLE->APPLY on start, APPLY->CHECK always, CHECK->APPLY if vectors remain else DONE, DONE->IDLE always.
REQ-016 Accepted start SHALL reload LFSR with SEED, set A=SEED, clear err_cnt, fail_*, pass, and set busy next cycle.
REQ-017 start while busy or in DONE SHALL be ignored.
REQ-018 Each iteration SHALL apply five vectors in order: (A,~A,0), (A,~A,1), (A,A,1), (A',B',0), (A',B',1), where A',B' are the next two LFSR outputs loaded into A,B after vector 2's CHECK.
REQ-019 A SHALL retain A' into the next iteration.
REQ-020 dut_x/dut_y/dut_sub SHALL be registered, stable through APPLY and CHECK; comparison of dut_* inputs SHALL occur in CHECK.
REQ-021 Expected result: {cf,f} = 33-bit x+y when sub=0, 33-bit x-y when sub=1 (cf = bit 32, i.e. borrow).
REQ-022 Expected OF: sub=0: x31&y31&~f31 | ~x31&~y31&f31; sub=1: x31&~y31&~f31 | ~x31&y31&f31; SF=f31; ZF=(f==0).
REQ-023 Any mismatch on f, CF, OF, SF or ZF SHALL count as one error for that vector.
REQ-024 On first error of a run, fail_x/fail_y/fail_sub SHALL capture the vector; later errors SHALL not overwrite.
REQ-025 Timing: start at cycle t -> vector k APPLY at t+1+2k, CHECK at t+2+2k; done=1 at t+10*iter+1; busy high t+1 through t+10*iter.
REQ-026 iter=0 SHALL go directly to DONE at t+1 with pass=1, err_cnt=0.
REQ-027 pass SHALL equal (err_cnt==0) and update at the done cycle.
REQ-028 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), advancing only when generating A',B'.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, pass=0, err_cnt=0, fail_*=0, dut_*=0, A=B=0, LFSR=SEED.
REQ-030 Reset mid-run SHALL abort with no done pulse; a start after release SHALL begin a fresh run.

Structure
REQ-031 Package adder_bist_pkg SHALL hold the FSM state type, vector-index constants (0-4) and LFSR mask constant.
REQ-032 One sub-module lfsr32 (load, step, seed, value) SHALL implement REQ-028; expected-result logic stays in adder_bist.

Verification
REQ-033 Golden Adder32, SEED=1, iter=1: first APPLY x=00000001, y=FFFFFFFE, sub=0 -> f=FFFFFFFF, CF=0; done at t+11, pass=1, err_cnt=0.
REQ-034 Golden Adder32, iter=1000 -> done at t+10001, pass=1, err_cnt=0.
REQ-035 Fault model ZF stuck 0, iter=1 -> vector 2 (1,1,1) fails; fail_x=1, fail_y=1, fail_sub=1, err_cnt=1, pass=0.
REQ-036 iter=0 -> done at t+1, pass=1; start pulsed while busy (iter=5) -> no restart, done at t+51.
REQ-037 Reset asserted at t+7 of iter=3 run -> IDLE, all outputs zero, no done; restart iter=1 -> identical vectors to REQ-033.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg -- shared types and constants for the Adder32 built-in self-test.
// Holds the controller state type, the per-iteration vector indices, the LFSR
// feedback mask and the single-step Galois LFSR helper.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Position of a vector inside one five-vector iteration
    localparam logic [2:0] VEC_0 = 3'd0;   // (A, ~A, add)
    localparam logic [2:0] VEC_1 = 3'd1;   // (A, ~A, sub)
    localparam logic [2:0] VEC_2 = 3'd2;   // (A,  A, sub)
    localparam logic [2:0] VEC_3 = 3'd3;   // (A', B', add)
    localparam logic [2:0] VEC_4 = 3'd4;   // (A', B', sub)

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // One right-shifting Galois step
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] fb;
        fb        = s[0] ? LFSR_MASK : 32'h0000_0000;
        lfsr_next = (s >> 1) ^ fb;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// lfsr32 -- 32-bit Galois LFSR used as the operand source of adder_bist.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   synchronous active-low reset (state returns to seed)
//   seed  in   32-bit seed, must be non-zero
//   load  in   reload the state with seed
//   step  in   advance by two Galois steps (one A'/B' operand pair consumed)
//   value out  current state; the next two outputs are derived from it
module lfsr32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seed,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);
    import adder_bist_pkg::*;

    logic [31:0] value_r;

    // LFSR state register; a step consumes two outputs (A' then B')
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_r <= seed;
        end else if (load) begin
            value_r <= seed;
        end else if (step) begin
            value_r <= lfsr_next(lfsr_next(value_r));
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/adder_bist.sv
// adder_bist -- self-test controller for a 32-bit add/subtract unit (Adder32).
// Drives five operand vectors per iteration, checks result and flags against
// an internal expected-value model, counts mismatches and records the first
// failing vector.
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   start, iter[15:0]         run request (IDLE only) and iteration count
//   dut_x, dut_y, dut_sub     registered operands towards Adder32
//   dut_f, dut_cf/of/sf/zf    Adder32 result and flags
//   busy, done, pass          run status (done is a one-cycle pulse)
//   err_cnt[15:0]             saturating mismatch count
//   fail_x, fail_y, fail_sub  first failing vector of the run
module adder_bist #(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] iter,
    output logic [31:0] dut_x,
    output logic [31:0] dut_y,
    output logic        dut_sub,
    input  logic [31:0] dut_f,
    input  logic        dut_cf,
    input  logic        dut_of,
    input  logic        dut_sf,
    input  logic        dut_zf,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [31:0] fail_x,
    output logic [31:0] fail_y,
    output logic        fail_sub
);
    import adder_bist_pkg::*;

    // A zero seed would lock the LFSR at zero
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

    // Expected {cf, of, sf, zf, f}; cf is carry on add and borrow on subtract
    function automatic logic [35:0] expect_result(input logic [31:0] x,
                                                  input logic [31:0] y,
                                                  input logic        sub);
        logic [32:0] r;
        logic        of;
        if (sub) begin
            r  = {1'b0, x} - {1'b0, y};
            of = (x[31] & ~y[31] & ~r[31]) | (~x[31] & y[31] & r[31]);
        end else begin
            r  = {1'b0, x} + {1'b0, y};
            of = (x[31] & y[31] & ~r[31]) | (~x[31] & ~y[31] & r[31]);
        end
        expect_result = {r[32], of, r[31], (r[31:0] == 32'h0000_0000), r[31:0]};
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  vec_idx_r;
    logic [15:0] iter_left_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] dut_x_r;
    logic [31:0] dut_y_r;
    logic        dut_sub_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic [15:0] err_cnt_r;
    logic [31:0] fail_x_r;
    logic [31:0] fail_y_r;
    logic        fail_sub_r;

    logic [31:0] lfsr_value_s;
    logic [31:0] a_next_s;
    logic [31:0] b_next_s;
    logic        lfsr_load_s;
    logic        lfsr_step_s;
    logic        start_ok_s;
    logic        last_vec_s;
    logic [35:0] exp_s;
    logic [35:0] obs_s;
    logic        mismatch_s;
    logic [15:0] err_cnt_next_s;

    assign start_ok_s  = (state_r == ST_IDLE) && start;
    assign last_vec_s  = (vec_idx_r == VEC_4) && (iter_left_r == 16'd1);
    assign a_next_s    = lfsr_next(lfsr_value_s);
    assign b_next_s    = lfsr_next(a_next_s);
    assign lfsr_load_s = start_ok_s;
    assign lfsr_step_s = (state_r == ST_CHECK) && (vec_idx_r == VEC_2);

    // Operands stay registered through APPLY and CHECK, so the result seen in
    // CHECK belongs to the vector currently on dut_x/dut_y/dut_sub.
    assign exp_s      = expect_result(dut_x_r, dut_y_r, dut_sub_r);
    assign obs_s      = {dut_cf, dut_of, dut_sf, dut_zf, dut_f};
    assign mismatch_s = (state_r == ST_CHECK) && (obs_s != exp_s);

    // Saturating error count after the current CHECK
    always_comb begin
        err_cnt_next_s = err_cnt_r;
        if (mismatch_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_next_s = err_cnt_r + 16'd1;
        end else begin
            err_cnt_next_s = err_cnt_r;
        end
    end

    lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED_EFF),
        .load  (lfsr_load_s),
        .step  (lfsr_step_s),
        .value (lfsr_value_s)
    );

    // Controller state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero iteration count skips straight to DONE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = (iter == 16'd0) ? ST_DONE : ST_APPLY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_APPLY: state_next_s = ST_CHECK;
            ST_CHECK: begin
                if (last_vec_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_APPLY;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: vector sequencing, checking, status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_idx_r   <= VEC_0;
            iter_left_r <= 16'd0;
            a_r         <= 32'h0000_0000;
            b_r         <= 32'h0000_0000;
            dut_x_r     <= 32'h0000_0000;
            dut_y_r     <= 32'h0000_0000;
            dut_sub_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_cnt_r   <= 16'd0;
            fail_x_r    <= 32'h0000_0000;
            fail_y_r    <= 32'h0000_0000;
            fail_sub_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_APPLY) || (state_next_s == ST_CHECK);
            done_r <= (state_next_s == ST_DONE);
            if (start_ok_s) begin
                iter_left_r <= iter;
                vec_idx_r   <= VEC_0;
                a_r         <= SEED_EFF;
                dut_x_r     <= SEED_EFF;
                dut_y_r     <= ~SEED_EFF;
                dut_sub_r   <= 1'b0;
                err_cnt_r   <= 16'd0;
                fail_x_r    <= 32'h0000_0000;
                fail_y_r    <= 32'h0000_0000;
                fail_sub_r  <= 1'b0;
                // An empty run is trivially clean
                pass_r      <= (iter == 16'd0);
            end else if (state_r == ST_CHECK) begin
                err_cnt_r <= err_cnt_next_s;
                // err_cnt saturates and never wraps to zero, so zero means
                // no earlier failure in this run
                if (mismatch_s && (err_cnt_r == 16'd0)) begin
                    fail_x_r   <= dut_x_r;
                    fail_y_r   <= dut_y_r;
                    fail_sub_r <= dut_sub_r;
                end
                if (last_vec_s) begin
                    pass_r <= (err_cnt_next_s == 16'd0);
                end
                case (vec_idx_r)
                    VEC_0: begin
                        dut_x_r   <= a_r;
                        dut_y_r   <= ~a_r;
                        dut_sub_r <= 1'b1;
                        vec_idx_r <= VEC_1;
                    end
                    VEC_1: begin
                        dut_x_r   <= a_r;
                        dut_y_r   <= a_r;
                        dut_sub_r <= 1'b1;
                        vec_idx_r <= VEC_2;
                    end
                    VEC_2: begin
                        // Fresh LFSR operands; A keeps A' into the next iteration
                        a_r       <= a_next_s;
                        b_r       <= b_next_s;
                        dut_x_r   <= a_next_s;
                        dut_y_r   <= b_next_s;
                        dut_sub_r <= 1'b0;
                        vec_idx_r <= VEC_3;
                    end
                    VEC_3: begin
                        dut_x_r   <= a_r;
                        dut_y_r   <= b_r;
                        dut_sub_r <= 1'b1;
                        vec_idx_r <= VEC_4;
                    end
                    VEC_4: begin
                        dut_x_r     <= a_r;
                        dut_y_r     <= ~a_r;
                        dut_sub_r   <= 1'b0;
                        vec_idx_r   <= VEC_0;
                        iter_left_r <= iter_left_r - 16'd1;
                    end
                    default: begin
                        vec_idx_r <= VEC_0;
                    end
                endcase
            end
        end
    end

    assign dut_x    = dut_x_r;
    assign dut_y    = dut_y_r;
    assign dut_sub  = dut_sub_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_cnt  = err_cnt_r;
    assign fail_x   = fail_x_r;
    assign fail_y   = fail_y_r;
    assign fail_sub = fail_sub_r;

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist -- self-checking bench for adder_bist. A behavioural Adder32
// (optionally with ZF stuck at 0) answers the BIST; a reference model builds
// the expected vector list and outcome of each run from the LFSR definition.
module tb_adder_bist;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] iter = 16'd0;
    logic [31:0] dut_x, dut_y, dut_f, fail_x, fail_y;
    logic        dut_sub, dut_cf, dut_of, dut_sf, dut_zf, fail_sub;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    bit          zf_stuck0 = 1'b0;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        sub;
    } vec_t;

    vec_t exp_q[$];

    always #5 clk = ~clk;

    adder_bist #(.SEED(32'h0000_0001)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iter(iter),
        .dut_x(dut_x), .dut_y(dut_y), .dut_sub(dut_sub),
        .dut_f(dut_f), .dut_cf(dut_cf), .dut_of(dut_of), .dut_sf(dut_sf), .dut_zf(dut_zf),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_x(fail_x), .fail_y(fail_y), .fail_sub(fail_sub)
    );

    // Arithmetic Adder32: {cf, of, sf, zf, f}, overflow from signed range
    function automatic logic [35:0] ref_adder(input logic [31:0] x, input logic [31:0] y,
                                              input logic sub);
        longint      sx, sy, r;
        logic [31:0] f;
        logic        cf, of;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sub) begin
            r  = sx - sy;
            f  = x - y;
            cf = (x < y);
        end else begin
            r  = sx + sy;
            f  = x + y;
            cf = (({32'd0, x} + {32'd0, y}) > 64'h0000_0000_FFFF_FFFF);
        end
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {cf, of, f[31], (f == 32'd0), f};
    endfunction

    logic [35:0] adder_out;
    always_comb begin
        adder_out = ref_adder(dut_x, dut_y, dut_sub);
        if (zf_stuck0) adder_out[32] = 1'b0;
    end
    assign {dut_cf, dut_of, dut_sf, dut_zf, dut_f} = adder_out;

    function automatic logic [31:0] gal(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected vector list: per iteration (A,~A,+) (A,~A,-) (A,A,-) then two
    // fresh LFSR outputs A',B' as (A',B',+) (A',B',-), A' carried forward
    task automatic build(input int n_iter);
        logic [31:0] a, b, l;
        exp_q.delete();
        a = 32'h0000_0001;
        l = 32'h0000_0001;
        for (int i = 0; i < n_iter; i++) begin
            exp_q.push_back('{a, ~a, 1'b0});
            exp_q.push_back('{a, ~a, 1'b1});
            exp_q.push_back('{a, a, 1'b1});
            l = gal(l); a = l;
            l = gal(l); b = l;
            exp_q.push_back('{a, b, 1'b0});
            exp_q.push_back('{a, b, 1'b1});
        end
    endtask

    // One run: start, check every cycle up to done (or abort by reset at abort_at)
    task automatic run(input int n_iter, input bit fault, input int pulse_at, input int abort_at);
        int          exp_err, last_n, n, k;
        logic [31:0] ffx, ffy;
        logic        ffs;
        logic [35:0] good, bad;
        bit          finished;
        build(n_iter);
        zf_stuck0 = fault;
        exp_err = 0; ffx = 32'd0; ffy = 32'd0; ffs = 1'b0;
        foreach (exp_q[i]) begin
            good = ref_adder(exp_q[i].x, exp_q[i].y, exp_q[i].sub);
            bad  = good;
            if (fault) bad[32] = 1'b0;
            if (bad != good) begin
                if (exp_err == 0) begin
                    ffx = exp_q[i].x; ffy = exp_q[i].y; ffs = exp_q[i].sub;
                end
                exp_err++;
            end
        end
        last_n = 10 * n_iter + 1;
        @(negedge clk); start = 1'b1; iter = 16'(n_iter);
        @(negedge clk); start = 1'b0;
        n = 1; finished = 1'b0;
        while (!finished) begin
            if (n == pulse_at) begin
                start = 1'b1; iter = 16'd2;
            end else begin
                start = 1'b0;
            end
            if (n < last_n) begin
                k = (n - 1) / 2;
                chk("busy", 64'(busy), 64'd1);
                chk("done_early", 64'(done), 64'd0);
                chk("dut_x", 64'(dut_x), 64'(exp_q[k].x));
                chk("dut_y", 64'(dut_y), 64'(exp_q[k].y));
                chk("dut_sub", 64'(dut_sub), 64'(exp_q[k].sub));
                if (n % 2 == 1) n_vec++;
            end else begin
                chk("done", 64'(done), 64'd1);
                chk("busy_end", 64'(busy), 64'd0);
                chk("pass", 64'(pass), 64'(exp_err == 0));
                chk("err_cnt", 64'(err_cnt), 64'(exp_err));
                chk("fail_x", 64'(fail_x), 64'(ffx));
                chk("fail_y", 64'(fail_y), 64'(ffy));
                chk("fail_sub", 64'(fail_sub), 64'(ffs));
                finished = 1'b1;
            end
            if (n == abort_at) begin
                rst_n = 1'b0;
                finished = 1'b1;
            end
            if (!finished) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_err"}, 64'(err_cnt), 64'd0);
        chk({tag, "_fail"}, {fail_x, fail_y}, 64'd0);
        chk({tag, "_fsub"}, 64'(fail_sub), 64'd0);
        chk({tag, "_dut"}, {dut_x, dut_y}, 64'd0);
        chk({tag, "_dsub"}, 64'(dut_sub), 64'd0);
    endtask

    initial begin
        int ni;
        bit nf;
        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Golden, single iteration; first vector (1, FFFFFFFE, add)
        run(1, 1'b0, 0, 0);
        // Empty run
        run(0, 1'b0, 0, 0);
        // Start pulsed while busy is ignored
        run(5, 1'b0, 3, 0);
        // Start pulsed during DONE is ignored
        run(1, 1'b0, 11, 0);
        @(negedge clk); start = 1'b0;
        chk("idle_after_done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("no_restart_busy", 64'(busy), 64'd0);
        chk("no_restart_done", 64'(done), 64'd0);

        // ZF stuck at 0: (1,1,sub) is the first failure
        run(1, 1'b1, 0, 0);
        chk("fault_fail_x", 64'(fail_x), 64'd1);
        chk("fault_err", 64'(err_cnt), 64'd1);

        // Reset during an iter=3 run at t+7
        run(3, 1'b0, 0, 7);
        @(negedge clk);
        chk_all_zero("abort");
        @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_done", 64'(done), 64'd0);
        run(1, 1'b0, 0, 0);

        // Randomized runs, with and without the ZF fault
        for (int r = 0; r < 6; r++) begin
            ni = int'($urandom_range(1, 20));
            nf = bit'($urandom_range(0, 1));
            run(ni, nf, 0, 0);
        end

        // Long golden run
        run(1000, 1'b0, 0, 0);
        @(negedge clk);
        start = 1'b0;

        chk("enough_checks", 64'(n_cmp >= 12), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
